// File: rtl/carrier_nco.sv
// carrier_nco: loop-driven frequency word, 32-bit phase accumulator and quarter-wave sin/cos LUT.
// Optional phase dither from a 16-bit LFSR is compiled in with `define NCO_DITHER_EN.
module carrier_nco #(
    parameter int LUT_BITS = 10,
    parameter int OUT_W    = 18
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clkEn,
    input  logic [31:0]             centerFreq,
    input  logic [31:0]             carrierFreqOffset,
    input  logic [31:0]             carrierLeadFreq,
    input  logic                    carrierFreqEn,
    input  logic                    leadEnable,
    input  logic                    phaseReset,
    output logic signed [OUT_W-1:0] sinOut,
    output logic signed [OUT_W-1:0] cosOut,
    output logic                    outEn,
    output logic [31:0]             freqWord
);
    localparam int  A_W = LUT_BITS - 2;
    localparam int  N   = 2 ** A_W;
    localparam real PI  = 3.14159265358979323846;

    // Table entries sample the half-step points so L[N-1-i] mirrors L[i] exactly.
    function automatic logic [OUT_W-1:0] lut_entry(input int i);
        real x;
        real term;
        real s;
        real amp;
        x    = (PI / 2.0) * (real'(i) + 0.5) / real'(N);
        term = x;
        s    = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        amp = real'((2 ** (OUT_W - 1)) - 1);
        return OUT_W'($rtoi(amp * s + 0.5));
    endfunction

    logic [31:0]         r_freq_word;
    logic [31:0]         r_acc;
    logic [31:0]         w_lead_term;
    logic [31:0]         w_freq_next;
    logic                r_s0_vld;
    logic [LUT_BITS-1:0] w_s0_idx;
    logic                r_s1_vld;
    logic [1:0]          r_s1_q;
    logic [A_W-1:0]      r_s1_a;
    logic                r_s2_vld;
    logic [1:0]          r_s2_q;
    logic [OUT_W-1:0]    r_s2_la;
    logic [OUT_W-1:0]    r_s2_lb;
    logic [OUT_W-1:0]    w_neg_la;
    logic [OUT_W-1:0]    w_neg_lb;
    logic [OUT_W-1:0]    w_sin;
    logic [OUT_W-1:0]    w_cos;
    logic [OUT_W-1:0]    r_sin;
    logic [OUT_W-1:0]    r_cos;
    logic                r_out_en;
    logic [OUT_W-1:0]    w_rom [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        localparam logic [OUT_W-1:0] LV = lut_entry(g);
        assign w_rom[g] = LV;
    end

    // Lead term is gated into the frequency sum
    always_comb begin
        w_lead_term = 32'd0;
        if (leadEnable) begin
            w_lead_term = carrierLeadFreq;
        end else begin
            w_lead_term = 32'd0;
        end
    end

    assign w_freq_next = centerFreq + carrierFreqOffset + w_lead_term;

    // Frequency word loads only on the loop strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_freq_word <= 32'd0;
        end else if (carrierFreqEn) begin
            r_freq_word <= w_freq_next;
        end
    end

    // Phase accumulator; phaseReset beats clkEn, and a coincident strobe still sees the old word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= 32'd0;
        end else if (phaseReset) begin
            r_acc <= 32'd0;
        end else if (clkEn) begin
            r_acc <= r_acc + r_freq_word;
        end
    end

    // Stage-0 valid tag follows the sample enable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s0_vld <= 1'b0;
        end else begin
            r_s0_vld <= clkEn;
        end
    end

`ifdef NCO_DITHER_EN
    logic [31:0] r_s0_acc;
    logic [15:0] r_s0_dith;
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    // The dither carry ripples into the index bits to break truncation spurs
    assign w_s0_idx  = LUT_BITS'((r_s0_acc + {16'd0, r_s0_dith}) >> (32 - LUT_BITS));

    // Dither LFSR steps once per sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= 16'hACE1;
        end else if (clkEn) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // Capture pre-add phase and the dither value paired with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s0_acc  <= 32'd0;
            r_s0_dith <= 16'd0;
        end else begin
            r_s0_acc  <= r_acc;
            r_s0_dith <= r_lfsr;
        end
    end
`else
    logic [LUT_BITS-1:0] r_s0_acc;

    assign w_s0_idx = r_s0_acc;

    // Capture the truncated pre-add phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s0_acc <= {LUT_BITS{1'b0}};
        end else begin
            r_s0_acc <= r_acc[31 -: LUT_BITS];
        end
    end
`endif

    // Split the phase index into quadrant and quarter-wave address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_vld <= 1'b0;
            r_s1_q   <= 2'd0;
            r_s1_a   <= {A_W{1'b0}};
        end else begin
            r_s1_vld <= r_s0_vld;
            r_s1_q   <= w_s0_idx[LUT_BITS-1 -: 2];
            r_s1_a   <= w_s0_idx[A_W-1:0];
        end
    end

    // Read the table at a and at its mirror N-1-a (bitwise complement)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_vld <= 1'b0;
            r_s2_q   <= 2'd0;
            r_s2_la  <= {OUT_W{1'b0}};
            r_s2_lb  <= {OUT_W{1'b0}};
        end else begin
            r_s2_vld <= r_s1_vld;
            r_s2_q   <= r_s1_q;
            r_s2_la  <= w_rom[r_s1_a];
            r_s2_lb  <= w_rom[~r_s1_a];
        end
    end

    assign w_neg_la = {OUT_W{1'b0}} - r_s2_la;
    assign w_neg_lb = {OUT_W{1'b0}} - r_s2_lb;

    // Quadrant map onto the quarter-wave magnitudes
    always_comb begin
        w_sin = r_s2_la;
        w_cos = r_s2_lb;
        case (r_s2_q)
            2'd0: begin
                w_sin = r_s2_la;
                w_cos = r_s2_lb;
            end
            2'd1: begin
                w_sin = r_s2_lb;
                w_cos = w_neg_la;
            end
            2'd2: begin
                w_sin = w_neg_la;
                w_cos = w_neg_lb;
            end
            2'd3: begin
                w_sin = w_neg_lb;
                w_cos = r_s2_la;
            end
            default: begin
                w_sin = {OUT_W{1'b0}};
                w_cos = {OUT_W{1'b0}};
            end
        endcase
    end

    // Output registers hold between valid samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sin    <= {OUT_W{1'b0}};
            r_cos    <= {OUT_W{1'b0}};
            r_out_en <= 1'b0;
        end else begin
            r_out_en <= r_s2_vld;
            if (r_s2_vld) begin
                r_sin <= w_sin;
                r_cos <= w_cos;
            end
        end
    end

    assign sinOut   = r_sin;
    assign cosOut   = r_cos;
    assign outEn    = r_out_en;
    assign freqWord = r_freq_word;

endmodule

// File: tb/tb_carrier_nco.sv
// Directed, table-driven bench for carrier_nco (default build, dither disabled).
module tb_carrier_nco;
    localparam int OUT_W = 18;

    logic                    clk;
    logic                    reset;
    logic                    clkEn;
    logic [31:0]             centerFreq;
    logic [31:0]             carrierFreqOffset;
    logic [31:0]             carrierLeadFreq;
    logic                    carrierFreqEn;
    logic                    leadEnable;
    logic                    phaseReset;
    logic signed [OUT_W-1:0] sinOut;
    logic signed [OUT_W-1:0] cosOut;
    logic                    outEn;
    logic [31:0]             freqWord;

    int n_checks = 0;
    int n_errors = 0;
    int exp_sin[$];
    int exp_cos[$];

    typedef struct {
        logic [31:0] center;
        logic [31:0] offs;
        logic [31:0] lead;
        logic        lead_en;
        logic [31:0] exp_fw;
    } fw_vec_t;

    typedef struct {
        int s;
        int c;
    } tone_t;

    fw_vec_t fw_tbl [6];
    tone_t   q_tbl  [4];
    tone_t   e_tbl  [8];

    carrier_nco #(.LUT_BITS(10), .OUT_W(OUT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .clkEn            (clkEn),
        .centerFreq       (centerFreq),
        .carrierFreqOffset(carrierFreqOffset),
        .carrierLeadFreq  (carrierLeadFreq),
        .carrierFreqEn    (carrierFreqEn),
        .leadEnable       (leadEnable),
        .phaseReset       (phaseReset),
        .sinOut           (sinOut),
        .cosOut           (cosOut),
        .outEn            (outEn),
        .freqWord         (freqWord)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int s, input int c);
        exp_sin.push_back(s);
        exp_cos.push_back(c);
    endtask

    task automatic program_fw(input logic [31:0] c);
        centerFreq        = c;
        carrierFreqOffset = 32'd0;
        carrierLeadFreq   = 32'd0;
        leadEnable        = 1'b0;
        carrierFreqEn     = 1'b1;
        tick();
        carrierFreqEn     = 1'b0;
        phaseReset        = 1'b1;
        tick();
        phaseReset        = 1'b0;
    endtask

    // Drives k back-to-back clkEn cycles (strobes preset by caller apply to the first) and checks samples.
    task automatic run_check(input string nm, input int k);
        int got;
        int first;
        got   = 0;
        first = -1;
        for (int c = 0; c < k + 8; c++) begin
            clkEn = (c < k);
            tick();
            carrierFreqEn = 1'b0;
            phaseReset    = 1'b0;
            if (outEn) begin
                if (first < 0) first = c;
                if (got < exp_sin.size()) begin
                    chk($sformatf("%s sin[%0d]", nm, got), sinOut, exp_sin[got]);
                    chk($sformatf("%s cos[%0d]", nm, got), cosOut, exp_cos[got]);
                end
                got++;
            end
        end
        clkEn = 1'b0;
        chk({nm, " outEn count"}, got, k);
        chk({nm, " latency"}, first, 3);
        exp_sin.delete();
        exp_cos.delete();
    endtask

    initial begin
        int seen;

        fw_tbl[0] = '{32'hFFFFFFF0, 32'h00000020, 32'h00000000, 1'b0, 32'h00000010};
        fw_tbl[1] = '{32'h00001000, 32'h00000010, 32'h00000100, 1'b0, 32'h00001010};
        fw_tbl[2] = '{32'h00001000, 32'h00000010, 32'h00000100, 1'b1, 32'h00001110};
        fw_tbl[3] = '{32'h40000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 32'h3FFFFFFF};
        fw_tbl[4] = '{32'h00000100, 32'h00000000, 32'hFFFFFF00, 1'b1, 32'h00000000};
        fw_tbl[5] = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF};

        q_tbl[0] = '{402, 131070};
        q_tbl[1] = '{131070, -402};
        q_tbl[2] = '{-402, -131070};
        q_tbl[3] = '{-131070, 402};

        e_tbl[0] = '{402, 131070};
        e_tbl[1] = '{92965, 92396};
        e_tbl[2] = '{131070, -402};
        e_tbl[3] = '{92396, -92965};
        e_tbl[4] = '{-402, -131070};
        e_tbl[5] = '{-92965, -92396};
        e_tbl[6] = '{-131070, 402};
        e_tbl[7] = '{-92396, 92965};

        reset             = 1'b0;
        clkEn             = 1'b0;
        centerFreq        = 32'd0;
        carrierFreqOffset = 32'd0;
        carrierLeadFreq   = 32'd0;
        carrierFreqEn     = 1'b0;
        leadEnable        = 1'b0;
        phaseReset        = 1'b0;
        #2;
        chk("reset sinOut", sinOut, 0);
        chk("reset cosOut", cosOut, 0);
        chk("reset outEn", outEn, 0);
        chk("reset freqWord", freqWord, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Frequency word table
        for (int i = 0; i < 6; i++) begin
            centerFreq        = fw_tbl[i].center;
            carrierFreqOffset = fw_tbl[i].offs;
            carrierLeadFreq   = fw_tbl[i].lead;
            leadEnable        = fw_tbl[i].lead_en;
            carrierFreqEn     = 1'b1;
            tick();
            carrierFreqEn     = 1'b0;
            tick();
            chk($sformatf("freqWord vec %0d", i), freqWord, fw_tbl[i].exp_fw);
        end
        centerFreq = 32'h12345678;
        leadEnable = 1'b0;
        tick();
        tick();
        chk("freqWord hold without strobe", freqWord, 32'h7FFFFFFF);

        // Quarter-rate tone, two full turns
        program_fw(32'h40000000);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) push(q_tbl[i].s, q_tbl[i].c);
        run_check("quarter", 8);

        // Eighth-rate tone exercises mid-table addresses
        program_fw(32'h20000000);
        for (int i = 0; i < 8; i++) push(e_tbl[i].s, e_tbl[i].c);
        run_check("eighth", 8);

        // Strobe and clkEn on the same edge: advance uses the old word
        program_fw(32'h40000000);
        centerFreq    = 32'h80000000;
        carrierFreqEn = 1'b1;
        push(402, 131070);
        push(131070, -402);
        push(-131070, 402);
        run_check("coincide", 3);
        chk("coincide new freqWord", freqWord, 32'h80000000);

        // Phase reset coincident with clkEn after five samples
        program_fw(32'h40000000);
        for (int i = 0; i < 5; i++) push(q_tbl[i % 4].s, q_tbl[i % 4].c);
        run_check("pre-phaseReset", 5);
        phaseReset = 1'b1;
        push(131070, -402);
        push(402, 131070);
        run_check("phaseReset", 2);

        // Asynchronous reset in mid-stream
        program_fw(32'h40000000);
        clkEn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        #1;
        chk("midrun reset sinOut", sinOut, 0);
        chk("midrun reset cosOut", cosOut, 0);
        chk("midrun reset outEn", outEn, 0);
        chk("midrun reset freqWord", freqWord, 0);
        tick();
        tick();
        clkEn = 1'b0;
        reset = 1'b1;
        seen  = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (outEn) seen++;
        end
        chk("no outEn from flushed samples", seen, 0);
        push(402, 131070);
        run_check("post-reset pulse", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/carrier_nco.md
Name: carrier_nco

Overview:
- Carrier NCO directly downstream of the carrier tracking loop.
- Builds a 32-bit frequency word from three terms: the programmed centre frequency, the loop's lag-accumulator output and, optionally, the loop's lead term.
- Runs a phase accumulator on the DDC sample enable.
- Produces quadrature sin/cos from a quarter-wave LUT for the downconverter's complex mixer. This closes the carrier loop.

Parameters:
- LUT_BITS, 10: phase bits used for lookup. The top 2 bits select the quadrant; the remaining LUT_BITS-2 bits address the quarter-wave table (256 entries at default).
- OUT_W, 18: signed sin/cos output width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clkEn  in  1  sample enable (ddcSync); advances the accumulator
- centerFreq  in  32  programmed carrier frequency word (unsigned mod 2^32)
- carrierFreqOffset  in  32  loop lag term, two's complement
- carrierLeadFreq  in  32  loop lead term, two's complement
- carrierFreqEn  in  1  one-cycle strobe: loop terms are valid
- leadEnable  in  1  1 = include the lead term in the frequency word
- phaseReset  in  1  one-cycle strobe: zero the phase accumulator
- sinOut  out  OUT_W  signed sine
- cosOut  out  OUT_W  signed cosine
- outEn  out  1  sin/cos valid strobe
- freqWord  out  32  current frequency word (register readback)

Behaviour:
- Reset (reset=0, asynchronous):
  - freqWord, phase accumulator, pipeline registers, sinOut, cosOut and outEn all go to 0.
  - The LFSR (when compiled in) goes to its seed.
- Frequency word update:
  - On a clk edge with carrierFreqEn=1: freqWord <= centerFreq + carrierFreqOffset + (leadEnable ? carrierLeadFreq : 0), computed mod 2^32 with no saturation.
  - Without a strobe, freqWord holds. centerFreq changes take effect only at the next strobe.
- Phase accumulator (acc, 32 bits):
  - On a clk edge with clkEn=1: acc <= acc + freqWord. Wraps mod 2^32.
  - If carrierFreqEn and clkEn are high on the same edge, the accumulator uses the old freqWord. The new word applies from the next clkEn.
  - On a clk edge with phaseReset=1: acc <= 0. This has priority over clkEn.
  - If phaseReset and clkEn coincide, a sample is still issued for the pre-reset acc value.
- Pipeline: free-running, with a valid bit tagging clkEn.
  - S1: capture acc (the value before the add on the same edge). Compute idx = acc[31:32-LUT_BITS] (with dither, see Optional Feature). Output quadrant q = idx[LUT_BITS-1:LUT_BITS-2] and address a = idx[LUT_BITS-3:0].
  - S2: read L[a] and L[N-1-a], where N = 2^(LUT_BITS-2).
  - S3: quadrant map and register the outputs.
- Latency: clkEn sampled at edge n produces outEn=1 for the single cycle following edge n+3. Back-to-back clkEn gives back-to-back outEn. sinOut/cosOut hold between strobes.
- LUT contents: L[i] = round((2^(OUT_W-1)-1) * sin(pi/2 * (i+0.5)/N)). The half-step offset gives exact odd/even symmetry.
- Quadrant map:
  - q0: sin=L[a], cos=L[N-1-a]
  - q1: sin=L[N-1-a], cos=-L[a]
  - q2: sin=-L[a], cos=-L[N-1-a]
  - q3: sin=-L[N-1-a], cos=L[a]
- Negation is two's complement. It cannot overflow because |L| <= 2^(OUT_W-1)-1.
- Reset mid-operation clears in-flight samples. No outEn is emitted for samples that were in flight at reset.

Optional Feature:
- Macro: NCO_DITHER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR with taps x^16+x^14+x^13+x^11+1 and seed 16'hACE1 advances on each clkEn.
  - Its 16 bits, zero-extended, are added to acc[31-LUT_BITS:0] (the truncated part) before index extraction. The carry propagates into idx, which breaks phase-truncation spurs.
- Undefined: plain truncation and no LFSR logic. All Test Plan values assume the macro is undefined.

Test Plan:
- Reset: assert reset=0 mid-run with clkEn active -> all outputs 0 immediately. No outEn until 3 cycles after the first post-reset clkEn.
- Quarter-rate tone: centerFreq=0x40000000, offsets 0, one carrierFreqEn strobe, clkEn every cycle, defaults -> (sin,cos) repeats (402,131070), (131070,-402), (-402,-131070), (-131070,402), starting 3 cycles after the first clkEn.
- Frequency wrap: centerFreq=0xFFFFFFF0, carrierFreqOffset=0x00000020, strobe -> freqWord=0x00000010.
- Lead gating: centerFreq=0x1000, offset=0x10, lead=0x100, leadEnable=0 -> freqWord=0x1010. Set leadEnable=1 and strobe again -> freqWord=0x1110.
- Latency and coincidence: single clkEn pulse -> exactly one outEn, 3 cycles later. carrierFreqEn and clkEn together -> the accumulator advances by the old freqWord.
- Phase reset: after 5 samples at 0x40000000, pulse phaseReset together with clkEn -> the next-but-one sample is (402,131070), i.e. phase 0.
